// File: rtl/inport_capture_if.sv
// Handshake between the operator input port and the datapath's INPORT.
// The datapath drives INrd and observes the captured value and its status.
interface inport_capture_if;
    logic        INrd;
    logic [31:0] INPORTin;
    logic        ready;
    logic        overrun;

    modport master (
        output INrd,
        input  INPORTin,
        input  ready,
        input  overrun
    );

    modport slave (
        input  INrd,
        output INPORTin,
        output ready,
        output overrun
    );
endinterface

// File: rtl/inport_capture.sv
// Debounced push-button capture of the slide switches into a holding
// register, presented to the datapath with a ready/consumed handshake.
module inport_capture #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int WIDTH           = 8
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [WIDTH-1:0] SW,
    input  logic             key_n,
    inport_capture_if.slave  bus
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] HELD         = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    logic             key_s1_q;
    logic             key_s2_q;
    logic [WIDTH-1:0] sw_s1_q;
    logic [WIDTH-1:0] sw_s2_q;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             ready_q;
    logic             ready_d;
    logic             ovr_q;
    logic             ovr_d;

    logic             pressed;
    logic             cnt_done;
    logic             capture;

    assign pressed  = ~key_s2_q;
    assign cnt_done = (cnt_q == CNT_LAST);

    // Key idles released (high) so the synchronizer resets to 1.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_s1_q <= 1'b1;
            key_s2_q <= 1'b1;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
        end else begin
            key_s1_q <= key_n;
            key_s2_q <= key_s1_q;
            sw_s1_q  <= SW;
            sw_s2_q  <= sw_s1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = HELD;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_d = HELD;
                end else if (cnt_done) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A capture alongside INrd consumes the old value and keeps ready set.
    always_comb begin
        data_d  = data_q;
        ready_d = ready_q;
        ovr_d   = ovr_q;
        if (capture) begin
            data_d  = sw_s2_q;
            ready_d = 1'b1;
            if (ready_q && !bus.INrd) begin
                ovr_d = 1'b1;
            end
        end else if (bus.INrd && ready_q) begin
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.INPORTin = 32'(data_q);
    assign bus.ready    = ready_q;
    assign bus.overrun  = ovr_q;

endmodule

// File: tb/tb_inport_capture.sv
// Directed bench for inport_capture with DEBOUNCE_CYCLES=4, WIDTH=8.
// Table rows: apply inputs, run n cycles, compare outputs.
module tb_inport_capture;

    logic       CLOCK_50;
    logic       reset;
    logic [7:0] SW;
    logic       key_n;

    inport_capture_if bus ();

    inport_capture #(
        .DEBOUNCE_CYCLES(4),
        .WIDTH          (8)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .SW      (SW),
        .key_n   (key_n),
        .bus     (bus.slave)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic        rst;
        logic        key;
        logic [7:0]  sw;
        logic        rd;
        int          n;
        logic        er;
        logic [31:0] ed;
        logic        eo;
    } vec_t;

    vec_t vq[$];
    int   tests;
    int   failed;

    task automatic add(input logic rst, input logic key, input logic [7:0] sw,
                       input logic rd, input int n, input logic er,
                       input logic [31:0] ed, input logic eo);
        vec_t v;
        v.rst = rst; v.key = key; v.sw = sw; v.rd = rd;
        v.n = n; v.er = er; v.ed = ed; v.eo = eo;
        vq.push_back(v);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        int lat;
        tests = 0;
        failed = 0;
        reset = 1'b1;
        key_n = 1'b1;
        SW = 8'hA5;
        bus.INrd = 1'b0;

        // reset, idle
        add(1, 1, 8'hA5, 0, 2,  0, 32'h00, 0);
        add(0, 1, 8'hA5, 0, 50, 0, 32'h00, 0);
        // clean press, hold, release, consume
        add(0, 0, 8'hC0, 0, 6,  0, 32'h00, 0);
        add(0, 0, 8'hC0, 0, 1,  1, 32'hC0, 0);
        add(0, 0, 8'hFF, 0, 40, 1, 32'hC0, 0);
        add(0, 1, 8'hFF, 0, 8,  1, 32'hC0, 0);
        add(0, 1, 8'hFF, 1, 1,  0, 32'hC0, 0);
        add(0, 1, 8'hFF, 1, 1,  0, 32'hC0, 0);
        // bounce rejection
        for (int i = 0; i < 5; i++) begin
            add(0, 0, 8'h77, 0, 3, 0, 32'hC0, 0);
            add(0, 1, 8'h77, 0, 2, 0, 32'hC0, 0);
        end
        add(0, 0, 8'h12, 0, 6,  0, 32'hC0, 0);
        add(0, 0, 8'h12, 0, 1,  1, 32'h12, 0);
        // consume, then overrun
        add(0, 0, 8'h12, 1, 1,  0, 32'h12, 0);
        add(0, 1, 8'h34, 0, 7,  0, 32'h12, 0);
        add(0, 0, 8'h34, 0, 6,  0, 32'h12, 0);
        add(0, 0, 8'h34, 0, 1,  1, 32'h34, 0);
        add(0, 1, 8'h56, 0, 7,  1, 32'h34, 0);
        add(0, 0, 8'h56, 0, 6,  1, 32'h34, 0);
        add(0, 0, 8'h56, 0, 1,  1, 32'h56, 1);
        // reset clears overrun, then capture with INrd on the same edge
        add(1, 0, 8'h56, 0, 1,  0, 32'h00, 0);
        add(0, 1, 8'h9A, 0, 3,  0, 32'h00, 0);
        add(0, 0, 8'h9A, 0, 6,  0, 32'h00, 0);
        add(0, 0, 8'h9A, 0, 1,  1, 32'h9A, 0);
        add(0, 1, 8'hBC, 0, 7,  1, 32'h9A, 0);
        add(0, 0, 8'hBC, 0, 6,  1, 32'h9A, 0);
        add(0, 0, 8'hBC, 1, 1,  1, 32'hBC, 0);
        add(0, 0, 8'hBC, 0, 1,  1, 32'hBC, 0);
        // reset mid PRESS_WAIT with key held
        add(0, 1, 8'hDE, 0, 7,  1, 32'hBC, 0);
        add(0, 0, 8'hDE, 0, 3,  1, 32'hBC, 0);
        add(1, 0, 8'hDE, 0, 1,  0, 32'h00, 0);
        add(0, 0, 8'hDE, 0, 6,  0, 32'h00, 0);
        add(0, 0, 8'hDE, 0, 1,  1, 32'hDE, 0);

        step(1);
        foreach (vq[i]) begin
            reset    = vq[i].rst;
            key_n    = vq[i].key;
            SW       = vq[i].sw;
            bus.INrd = vq[i].rd;
            step(vq[i].n);
            chk("ready",    i, 32'(bus.ready),   32'(vq[i].er));
            chk("INPORTin", i, bus.INPORTin,     vq[i].ed);
            chk("overrun",  i, 32'(bus.overrun), 32'(vq[i].eo));
        end

        // press latency measured with a bounded wait
        reset = 1'b0;
        bus.INrd = 1'b1;
        step(1);
        bus.INrd = 1'b0;
        key_n = 1'b1;
        step(7);
        chk("consumed", 0, 32'(bus.ready), 32'd0);
        SW = 8'hF0;
        key_n = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            step(1);
            if (bus.ready) begin
                lat = c;
                break;
            end
        end
        chk("latency", 0, 32'(lat), 32'd7);
        chk("lat_data", 0, bus.INPORTin, 32'h000000F0);
        chk("lat_ovr", 0, 32'(bus.overrun), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
